// File: rtl/cursor_pkg.sv
// Shared cursor command encoding and control-character codes used by the
// terminal parser and the cursor engine.
package cursor_pkg;

  typedef enum logic [3:0] {
    CUP, CUU, CUD, CUF, CUB, IND, RI, NEL, HTS, TBC, DECSC, DECRC, CTRL, PUT, NOP
  } cursor_op_t;

  typedef enum logic {
    ST_IDLE,
    ST_SCROLL
  } engine_state_t;

  localparam logic [7:0] CH_BS = 8'o10;
  localparam logic [7:0] CH_HT = 8'o11;
  localparam logic [7:0] CH_LF = 8'o12;
  localparam logic [7:0] CH_VT = 8'o13;
  localparam logic [7:0] CH_FF = 8'o14;
  localparam logic [7:0] CH_CR = 8'o15;

  function automatic logic [8:0] min9(input logic [8:0] a, input logic [8:0] b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/tab_stops.sv
// Tab-stop map: one bit per column with set / clear / clear-all and a
// combinational search for the nearest stop strictly right of a column.
module tab_stops #(
  parameter int COLS      = 80,
  parameter int TAB_WIDTH = 8,
  localparam int CW = $clog2(COLS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          set_en,
  input  logic          clr_en,
  input  logic          clr_all,
  input  logic [CW-1:0] col,
  output logic          next_found,
  output logic [CW-1:0] next_col
);

  logic [COLS-1:0] stops_q, stops_d;

  function automatic logic [COLS-1:0] default_stops();
    logic [COLS-1:0] s;
    s = '0;
    for (int i = 1; i < COLS; i++) s[i] = ((i % TAB_WIDTH) == 0);
    return s;
  endfunction

  always_comb begin
    stops_d = stops_q;
    if (clr_all)     stops_d = '0;
    else if (clr_en) stops_d[col] = 1'b0;
    else if (set_en) stops_d[col] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) stops_q <= default_stops();
    else     stops_q <= stops_d;
  end

  // Scanning downwards leaves the nearest qualifying stop as the last hit.
  always_comb begin
    next_found = 1'b0;
    next_col   = '0;
    for (int i = COLS - 1; i >= 0; i--) begin
      if (stops_q[i] && (CW'(i) > col)) begin
        next_found = 1'b1;
        next_col   = CW'(i);
      end
    end
  end

endmodule

// File: rtl/cursor_engine.sv
// VT100-style cursor controller: executes handshaked cursor/character commands,
// issues scroll requests to the text buffer and strobes character writes.
module cursor_engine
  import cursor_pkg::*;
#(
  parameter int ROWS      = 24,
  parameter int COLS      = 80,
  parameter int CLK_HZ    = 100000000,
  parameter int BLINK_HZ  = 2,
  parameter int TAB_WIDTH = 8,
  localparam int RW = $clog2(ROWS),
  localparam int CW = $clog2(COLS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  cursor_op_t    cmd_op,
  input  logic [7:0]    cmd_pn1,
  input  logic [7:0]    cmd_pn2,
  input  logic [7:0]    cmd_char,
  input  logic          origin_mode,
  input  logic          auto_wrap,
  input  logic          lf_newline,
  input  logic          cur_enable,
  input  logic          blink_enable,
  input  logic [RW-1:0] scroll_top,
  input  logic [RW-1:0] scroll_bottom,
  output logic [RW-1:0] cur_row,
  output logic [CW-1:0] cur_col,
  output logic          cur_visible,
  output logic          scroll_valid,
  input  logic          scroll_ready,
  output logic          scroll_dir,
  output logic [RW-1:0] scroll_top_o,
  output logic [RW-1:0] scroll_bottom_o,
  output logic          put_valid,
  output logic [RW-1:0] put_row,
  output logic [CW-1:0] put_col
);

  localparam logic [8:0] ROW_MAX = 9'(ROWS - 1);
  localparam logic [8:0] COL_MAX = 9'(COLS - 1);
  localparam int HALF = CLK_HZ / (2 * BLINK_HZ);
  localparam int BW   = (HALF > 1) ? $clog2(HALF) : 1;

  engine_state_t state_q, state_d;
  logic [RW-1:0] row_q, row_d, sav_row_q, sav_row_d, top_o_q, top_o_d, bot_o_q, bot_o_d;
  logic [RW-1:0] put_row_q, put_row_d;
  logic [CW-1:0] col_q, col_d, sav_col_q, sav_col_d, put_col_q, put_col_d;
  logic          wrap_q, wrap_d, sav_wrap_q, sav_wrap_d, dir_q, dir_d;
  logic          put_strobe_q, put_strobe_d, put_pend_q, put_pend_d;
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          phase_q, phase_d;

  logic          tab_set, tab_clr, tab_clr_all, tab_found;
  logic [CW-1:0] tab_next;
  logic          scroll_req, scroll_dn;

  // Widened 9-bit operands so additions never wrap before clamping.
  logic [8:0] row9, col9, top9, bot9, pn, pl, pc, lo9, hi9, lf_row9, ri_row9;
  logic       in_region, lf_scroll, ri_scroll;

  assign row9      = 9'(row_q);
  assign col9      = 9'(col_q);
  assign top9      = 9'(scroll_top);
  assign bot9      = 9'(scroll_bottom);
  assign pn        = (cmd_pn1 == 8'd0) ? 9'd1 : {1'b0, cmd_pn1};
  assign pl        = (cmd_pn1 == 8'd0) ? 9'd0 : {1'b0, cmd_pn1} - 9'd1;
  assign pc        = (cmd_pn2 == 8'd0) ? 9'd0 : {1'b0, cmd_pn2} - 9'd1;
  assign in_region = (row9 >= top9) && (row9 <= bot9);
  assign lo9       = in_region ? top9 : 9'd0;
  assign hi9       = in_region ? bot9 : ROW_MAX;
  assign lf_scroll = (row9 == bot9);
  assign lf_row9   = lf_scroll ? row9 : min9(row9 + 9'd1, ROW_MAX);
  assign ri_scroll = (row9 == top9);
  assign ri_row9   = (ri_scroll || row9 == 9'd0) ? row9 : row9 - 9'd1;

  tab_stops #(.COLS(COLS), .TAB_WIDTH(TAB_WIDTH)) u_tabs (
    .clk        (clk),
    .rst        (rst),
    .set_en     (tab_set),
    .clr_en     (tab_clr),
    .clr_all    (tab_clr_all),
    .col        (col_q),
    .next_found (tab_found),
    .next_col   (tab_next)
  );

  always_comb begin
    state_d      = state_q;
    row_d        = row_q;
    col_d        = col_q;
    wrap_d       = wrap_q;
    sav_row_d    = sav_row_q;
    sav_col_d    = sav_col_q;
    sav_wrap_d   = sav_wrap_q;
    dir_d        = dir_q;
    top_o_d      = top_o_q;
    bot_o_d      = bot_o_q;
    put_strobe_d = 1'b0;
    put_pend_d   = put_pend_q;
    put_row_d    = put_row_q;
    put_col_d    = put_col_q;
    tab_set      = 1'b0;
    tab_clr      = 1'b0;
    tab_clr_all  = 1'b0;
    scroll_req   = 1'b0;
    scroll_dn    = 1'b0;
    unique case (state_q)
      ST_IDLE: if (cmd_valid) begin
        wrap_d = 1'b0;
        case (cmd_op)
          CUP: begin
            row_d = origin_mode ? RW'(min9(top9 + pl, bot9)) : RW'(min9(pl, ROW_MAX));
            col_d = CW'(min9(pc, COL_MAX));
          end
          CUU: row_d = RW'((row9 >= lo9 + pn) ? row9 - pn : lo9);
          CUD: row_d = RW'(min9(row9 + pn, hi9));
          CUF: col_d = CW'(min9(col9 + pn, COL_MAX));
          CUB: col_d = CW'((col9 >= pn) ? col9 - pn : 9'd0);
          IND: begin row_d = RW'(lf_row9); scroll_req = lf_scroll; end
          NEL: begin row_d = RW'(lf_row9); scroll_req = lf_scroll; col_d = '0; end
          RI:  begin row_d = RW'(ri_row9); scroll_req = ri_scroll; scroll_dn = 1'b1; end
          HTS: begin tab_set = 1'b1; wrap_d = wrap_q; end
          TBC: begin
            tab_clr     = (cmd_pn1 == 8'd0);
            tab_clr_all = (cmd_pn1 == 8'd3);
            wrap_d      = wrap_q;
          end
          DECSC: begin
            sav_row_d  = row_q;
            sav_col_d  = col_q;
            sav_wrap_d = wrap_q;
            wrap_d     = wrap_q;
          end
          DECRC: begin row_d = sav_row_q; col_d = sav_col_q; wrap_d = sav_wrap_q; end
          CTRL: begin
            case (cmd_char)
              CH_BS: col_d = CW'((col9 != 9'd0) ? col9 - 9'd1 : 9'd0);
              CH_HT: col_d = tab_found ? tab_next : CW'(COLS - 1);
              CH_LF, CH_VT, CH_FF: begin
                row_d      = RW'(lf_row9);
                scroll_req = lf_scroll;
                if (lf_newline) col_d = '0;
              end
              CH_CR: col_d = '0;
              default: ;
            endcase
          end
          PUT: begin
            // A deferred wrap performs NEL first; the write waits for any scroll.
            if (wrap_q && auto_wrap) begin
              row_d        = RW'(lf_row9);
              col_d        = CW'(1);
              put_row_d    = RW'(lf_row9);
              put_col_d    = '0;
              scroll_req   = lf_scroll;
              put_pend_d   = lf_scroll;
              put_strobe_d = ~lf_scroll;
            end else begin
              put_row_d    = row_q;
              put_col_d    = col_q;
              put_strobe_d = 1'b1;
              if (col9 < COL_MAX) col_d = col_q + 1'b1;
              else                wrap_d = 1'b1;
            end
          end
          default: ;
        endcase
        if (scroll_req) begin
          state_d = ST_SCROLL;
          dir_d   = scroll_dn;
          top_o_d = scroll_top;
          bot_o_d = scroll_bottom;
        end
      end
      ST_SCROLL: if (scroll_ready) begin
        state_d    = ST_IDLE;
        put_pend_d = 1'b0;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    phase_d     = phase_q;
    blink_cnt_d = blink_cnt_q + 1'b1;
    if (blink_cnt_q == BW'(HALF - 1)) begin
      blink_cnt_d = '0;
      phase_d     = ~phase_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      row_q        <= '0;
      col_q        <= '0;
      wrap_q       <= 1'b0;
      sav_row_q    <= '0;
      sav_col_q    <= '0;
      sav_wrap_q   <= 1'b0;
      dir_q        <= 1'b0;
      top_o_q      <= '0;
      bot_o_q      <= '0;
      put_strobe_q <= 1'b0;
      put_pend_q   <= 1'b0;
      put_row_q    <= '0;
      put_col_q    <= '0;
      blink_cnt_q  <= '0;
      phase_q      <= 1'b1;
    end else begin
      state_q      <= state_d;
      row_q        <= row_d;
      col_q        <= col_d;
      wrap_q       <= wrap_d;
      sav_row_q    <= sav_row_d;
      sav_col_q    <= sav_col_d;
      sav_wrap_q   <= sav_wrap_d;
      dir_q        <= dir_d;
      top_o_q      <= top_o_d;
      bot_o_q      <= bot_o_d;
      put_strobe_q <= put_strobe_d;
      put_pend_q   <= put_pend_d;
      put_row_q    <= put_row_d;
      put_col_q    <= put_col_d;
      blink_cnt_q  <= blink_cnt_d;
      phase_q      <= phase_d;
    end
  end

  assign cmd_ready       = (state_q == ST_IDLE);
  assign scroll_valid    = (state_q == ST_SCROLL);
  assign scroll_dir      = dir_q;
  assign scroll_top_o    = top_o_q;
  assign scroll_bottom_o = bot_o_q;
  assign cur_row         = row_q;
  assign cur_col         = col_q;
  assign put_row         = put_row_q;
  assign put_col         = put_col_q;
  assign put_valid       = put_strobe_q | (scroll_valid & put_pend_q & scroll_ready);
  assign cur_visible     = cur_enable & (~blink_enable | phase_q);

endmodule

// File: tb/tb_cursor_engine.sv
// Self-checking bench for cursor_engine: directed scenarios followed by
// randomized commands compared against a behavioural cursor model.
`timescale 1ns/1ps
module tb_cursor_engine;
  import cursor_pkg::*;

  localparam int ROWS = 24;
  localparam int COLS = 80;
  localparam int RW = 5;
  localparam int CW = 7;
  localparam int BLINK_HALF = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cmd_valid = 1'b0;
  cursor_op_t cmd_op = NOP;
  logic [7:0] cmd_pn1 = 8'd0, cmd_pn2 = 8'd0, cmd_char = 8'd0;
  logic origin_mode = 1'b0, auto_wrap = 1'b0, lf_newline = 1'b0;
  logic cur_enable = 1'b1, blink_enable = 1'b1;
  logic [RW-1:0] scroll_top = 5'd0, scroll_bottom = 5'd23;
  logic scroll_ready = 1'b0;
  logic cmd_ready, cur_visible, scroll_valid, scroll_dir, put_valid;
  logic [RW-1:0] cur_row, scroll_top_o, scroll_bottom_o, put_row;
  logic [CW-1:0] cur_col, put_col;

  int n_vec = 0;
  int n_err = 0;
  int blink_edges;

  int m_row, m_col, m_srow, m_scol;
  bit m_wrap, m_swrap;
  bit m_stops[COLS];
  bit exp_scroll, exp_dir, exp_put;
  int exp_prow, exp_pcol, exp_top, exp_bot;

  cursor_engine #(.CLK_HZ(8), .BLINK_HZ(1)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_pn1(cmd_pn1), .cmd_pn2(cmd_pn2), .cmd_char(cmd_char),
    .origin_mode(origin_mode), .auto_wrap(auto_wrap), .lf_newline(lf_newline),
    .cur_enable(cur_enable), .blink_enable(blink_enable),
    .scroll_top(scroll_top), .scroll_bottom(scroll_bottom),
    .cur_row(cur_row), .cur_col(cur_col), .cur_visible(cur_visible),
    .scroll_valid(scroll_valid), .scroll_ready(scroll_ready), .scroll_dir(scroll_dir),
    .scroll_top_o(scroll_top_o), .scroll_bottom_o(scroll_bottom_o),
    .put_valid(put_valid), .put_row(put_row), .put_col(put_col)
  );

  always #5 clk = ~clk;

  always @(posedge clk or posedge rst) begin
    if (rst) blink_edges <= 0;
    else     blink_edges <= blink_edges + 1;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("[TB] FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_row = 0; m_col = 0; m_wrap = 0;
    m_srow = 0; m_scol = 0; m_swrap = 0;
    for (int c = 0; c < COLS; c++) m_stops[c] = (c != 0) && (c % 8 == 0);
  endtask

  task automatic model_index();
    if (m_row == int'(scroll_bottom)) begin
      exp_scroll = 1; exp_dir = 0;
    end else begin
      m_row = imin(m_row + 1, ROWS - 1);
    end
  endtask

  task automatic model_step(input cursor_op_t op, input logic [7:0] p1, input logic [7:0] p2,
                            input logic [7:0] ch);
    int pn, pl, pc, top, bot, nx;
    bit in_reg;
    top = int'(scroll_top);
    bot = int'(scroll_bottom);
    pn = (p1 == 8'd0) ? 1 : int'(p1);
    pl = imax(int'(p1) - 1, 0);
    pc = imax(int'(p2) - 1, 0);
    exp_scroll = 0; exp_dir = 0; exp_put = 0;
    exp_top = top; exp_bot = bot;
    in_reg = (m_row >= top) && (m_row <= bot);
    if (!(op inside {PUT, DECSC, HTS, TBC})) m_wrap = 0;
    case (op)
      CUP: begin
        m_row = origin_mode ? imin(top + pl, bot) : imin(pl, ROWS - 1);
        m_col = imin(pc, COLS - 1);
      end
      CUU: m_row = imax(m_row - pn, in_reg ? top : 0);
      CUD: m_row = imin(m_row + pn, in_reg ? bot : ROWS - 1);
      CUF: m_col = imin(m_col + pn, COLS - 1);
      CUB: m_col = imax(m_col - pn, 0);
      IND: model_index();
      NEL: begin model_index(); m_col = 0; end
      RI: begin
        if (m_row == top) begin exp_scroll = 1; exp_dir = 1; end
        else m_row = imax(m_row - 1, 0);
      end
      HTS: m_stops[m_col] = 1;
      TBC: begin
        if (p1 == 8'd0) m_stops[m_col] = 0;
        else if (p1 == 8'd3) for (int c = 0; c < COLS; c++) m_stops[c] = 0;
      end
      DECSC: begin m_srow = m_row; m_scol = m_col; m_swrap = m_wrap; end
      DECRC: begin m_row = m_srow; m_col = m_scol; m_wrap = m_swrap; end
      CTRL: begin
        case (ch)
          CH_BS: m_col = imax(m_col - 1, 0);
          CH_HT: begin
            nx = COLS - 1;
            for (int c = COLS - 1; c > m_col; c--) if (m_stops[c]) nx = c;
            m_col = nx;
          end
          CH_LF, CH_VT, CH_FF: begin model_index(); if (lf_newline) m_col = 0; end
          CH_CR: m_col = 0;
          default: ;
        endcase
      end
      PUT: begin
        exp_put = 1;
        if (m_wrap && auto_wrap) begin
          model_index();
          exp_prow = m_row; exp_pcol = 0;
          m_col = 1; m_wrap = 0;
        end else begin
          exp_prow = m_row; exp_pcol = m_col;
          if (m_col < COLS - 1) m_col++;
          else m_wrap = 1;
        end
      end
      default: ;
    endcase
  endtask

  task automatic applyStimulus(input cursor_op_t op, input logic [7:0] p1, input logic [7:0] p2,
                               input logic [7:0] ch, input int rdy_delay);
    int waited;
    waited = 0;
    while (cmd_ready !== 1'b1 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    checkOutput("ready_before_cmd", 32'(cmd_ready), 1);
    model_step(op, p1, p2, ch);
    cmd_op = op; cmd_pn1 = p1; cmd_pn2 = p2; cmd_char = ch; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    checkOutput("cur_row", 32'(cur_row), m_row);
    checkOutput("cur_col", 32'(cur_col), m_col);
    checkOutput("scroll_valid", 32'(scroll_valid), 32'(exp_scroll));
    if (exp_scroll) begin
      checkOutput("scroll_dir", 32'(scroll_dir), 32'(exp_dir));
      checkOutput("scroll_top_o", 32'(scroll_top_o), exp_top);
      checkOutput("scroll_bottom_o", 32'(scroll_bottom_o), exp_bot);
      checkOutput("ready_in_scroll", 32'(cmd_ready), 0);
      checkOutput("put_before_hs", 32'(put_valid), 0);
      for (int i = 0; i < rdy_delay; i++) begin
        @(negedge clk);
        checkOutput("stall_scroll_valid", 32'(scroll_valid), 1);
        checkOutput("stall_ready", 32'(cmd_ready), 0);
        checkOutput("stall_put", 32'(put_valid), 0);
        checkOutput("stall_row", 32'(cur_row), m_row);
      end
      scroll_ready = 1'b1;
      #1;
      checkOutput("put_in_hs", 32'(put_valid), 32'(exp_put));
      if (exp_put) begin
        checkOutput("put_row_hs", 32'(put_row), exp_prow);
        checkOutput("put_col_hs", 32'(put_col), exp_pcol);
      end
      @(negedge clk);
      scroll_ready = 1'b0;
      checkOutput("scroll_released", 32'(scroll_valid), 0);
      checkOutput("ready_after_hs", 32'(cmd_ready), 1);
      checkOutput("put_after_hs", 32'(put_valid), 0);
      checkOutput("row_after_hs", 32'(cur_row), m_row);
    end else begin
      checkOutput("put_valid", 32'(put_valid), 32'(exp_put));
      if (exp_put) begin
        checkOutput("put_row", 32'(put_row), exp_prow);
        checkOutput("put_col", 32'(put_col), exp_pcol);
      end
      checkOutput("ready_after_cmd", 32'(cmd_ready), 1);
    end
  endtask

  task automatic doReset();
    rst = 1'b1; cmd_valid = 1'b0; scroll_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  function automatic logic exp_visible();
    return cur_enable & (~blink_enable | ((blink_edges / BLINK_HALF) % 2 == 0));
  endfunction

  initial begin
    int top_r;
    cursor_op_t op;
    logic [7:0] p1, p2, ch;

    doReset();
    checkOutput("rst_row", 32'(cur_row), 0);
    checkOutput("rst_col", 32'(cur_col), 0);
    checkOutput("rst_ready", 32'(cmd_ready), 1);
    checkOutput("rst_scroll_valid", 32'(scroll_valid), 0);
    checkOutput("rst_put_valid", 32'(put_valid), 0);
    checkOutput("rst_put_row", 32'(put_row), 0);
    checkOutput("rst_put_col", 32'(put_col), 0);
    checkOutput("rst_visible", 32'(cur_visible), 1);

    applyStimulus(DECRC, 8'd0, 8'd0, 8'd0, 0);
    checkOutput("decrc_after_rst", {20'd0, 32'(cur_row) == 0, 11'd0}, {20'd0, 1'b1, 11'd0});
    checkOutput("decrc_col_after_rst", 32'(cur_col), 0);

    applyStimulus(CTRL, 8'd0, 8'd0, CH_HT, 0);
    checkOutput("ht_from_0", 32'(cur_col), 8);
    applyStimulus(CUP, 8'd1, 8'd80, 8'd0, 0);
    applyStimulus(CTRL, 8'd0, 8'd0, CH_HT, 0);
    checkOutput("ht_from_79", 32'(cur_col), 79);
    applyStimulus(CUP, 8'd1, 8'd4, 8'd0, 0);
    applyStimulus(HTS, 8'd0, 8'd0, 8'd0, 0);
    applyStimulus(CTRL, 8'd0, 8'd0, CH_CR, 0);
    applyStimulus(CTRL, 8'd0, 8'd0, CH_HT, 0);
    checkOutput("ht_to_hts_3", 32'(cur_col), 3);

    origin_mode = 1'b1; scroll_top = 5'd5; scroll_bottom = 5'd10;
    applyStimulus(CUP, 8'd20, 8'd0, 8'd0, 0);
    checkOutput("cup_origin_row", 32'(cur_row), 10);
    checkOutput("cup_origin_col", 32'(cur_col), 0);
    origin_mode = 1'b0; scroll_top = 5'd0; scroll_bottom = 5'd23;

    applyStimulus(CUP, 8'd24, 8'd1, 8'd0, 0);
    applyStimulus(CTRL, 8'd0, 8'd0, CH_LF, 5);
    checkOutput("lf_bottom_row", 32'(cur_row), 23);

    auto_wrap = 1'b1;
    applyStimulus(CUP, 8'd6, 8'd80, 8'd0, 0);
    applyStimulus(PUT, 8'd0, 8'd0, 8'h41, 0);
    checkOutput("put_a_col", 32'(cur_col), 79);
    applyStimulus(PUT, 8'd0, 8'd0, 8'h42, 0);
    checkOutput("put_b_row", 32'(cur_row), 6);
    checkOutput("put_b_col", 32'(cur_col), 1);
    applyStimulus(CUP, 8'd24, 8'd80, 8'd0, 0);
    applyStimulus(PUT, 8'd0, 8'd0, 8'h41, 0);
    applyStimulus(PUT, 8'd0, 8'd0, 8'h42, 3);
    checkOutput("put_wrap_bottom_row", 32'(cur_row), 23);
    checkOutput("put_wrap_bottom_col", 32'(cur_col), 1);

    applyStimulus(CUP, 8'd5, 8'd8, 8'd0, 0);
    applyStimulus(DECSC, 8'd0, 8'd0, 8'd0, 0);
    applyStimulus(CUP, 8'd1, 8'd1, 8'd0, 0);
    applyStimulus(DECRC, 8'd0, 8'd0, 8'd0, 0);
    checkOutput("decrc_row", 32'(cur_row), 4);
    checkOutput("decrc_col", 32'(cur_col), 7);

    cur_enable = 1'b1; blink_enable = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      checkOutput("blink_phase", 32'(cur_visible), 32'(exp_visible()));
    end
    blink_enable = 1'b0; #1;
    checkOutput("blink_off_visible", 32'(cur_visible), 1);
    cur_enable = 1'b0; #1;
    checkOutput("cursor_disabled", 32'(cur_visible), 0);
    cur_enable = 1'b1; blink_enable = 1'b1;

    applyStimulus(CUP, 8'd24, 8'd1, 8'd0, 0);
    cmd_op = CTRL; cmd_char = CH_LF; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    checkOutput("pre_rst_scroll", 32'(scroll_valid), 1);
    @(negedge clk);
    rst = 1'b1; #1;
    checkOutput("rst_mid_scroll_valid", 32'(scroll_valid), 0);
    checkOutput("rst_mid_ready", 32'(cmd_ready), 1);
    checkOutput("rst_mid_row", 32'(cur_row), 0);
    checkOutput("rst_mid_visible", 32'(cur_visible), 1);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checkOutput("blink_after_rst", 32'(cur_visible), 32'(exp_visible()));
    end

    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 7) == 0) begin
        top_r = $urandom_range(0, ROWS - 1);
        scroll_top = 5'(top_r);
        scroll_bottom = 5'($urandom_range(top_r, ROWS - 1));
        origin_mode = 1'($urandom_range(0, 1));
        auto_wrap = 1'($urandom_range(0, 1));
        lf_newline = 1'($urandom_range(0, 1));
      end
      op = cursor_op_t'($urandom_range(0, 14));
      if ($urandom_range(0, 3) == 0) op = PUT;
      p1 = ($urandom_range(0, 5) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 10));
      p2 = ($urandom_range(0, 5) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 85));
      if (op == TBC) p1 = 8'($urandom_range(0, 3));
      ch = (op == CTRL) ? 8'(8 + $urandom_range(0, 6)) : 8'($urandom_range(32, 126));
      applyStimulus(op, p1, p2, ch, $urandom_range(0, 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
